// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: snoops register write-back to track the done, pass and
// test-number registers of a compliance test, counts RUN/SETTLE cycles and
// taken jumps, and holds a sticky pass/fail/timeout verdict.
// All inputs pass through one register stage before any decision is made.
module riscv_test_monitor #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int DONE_REG    = 26,
    parameter int PASS_REG    = 27,
    parameter int TNUM_REG    = 3,
    parameter int SETTLE_CYC  = 20,
    parameter int TIMEOUT_CYC = 500000,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              jump_flag,
    output logic [2:0]        state,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] fail_testnum,
    output logic [DATA_W-1:0] cur_testnum,
    output logic              testnum_chg,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  jump_cnt
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_PASS    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    state_t state_q, state_nx;

    logic              en_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              jump_q;

    logic              pass_sh;
    logic [DATA_W-1:0] tnum_sh;
    logic [SET_W-1:0]  settle_cnt;

    logic              wr_ok, tnum_wr, pass_wr, done_wr;
    logic              pass_fwd;
    logic [DATA_W-1:0] tnum_fwd;
    logic              run_start, counting, timeout_hit, settle_last, enter_fail;

    // Decoded write-back events; index 0 is the hard-wired zero register.
    assign wr_ok       = wr_en_q && (wr_addr_q != '0);
    assign tnum_wr     = wr_ok && (wr_addr_q == ADDR_W'(TNUM_REG));
    assign pass_wr     = wr_ok && (wr_addr_q == ADDR_W'(PASS_REG));
    assign done_wr     = wr_ok && (wr_addr_q == ADDR_W'(DONE_REG)) && (wr_data_q == DATA_W'(1));
    // A shadow write landing on the decision cycle is forwarded into it.
    assign pass_fwd    = pass_wr ? (wr_data_q == DATA_W'(1)) : pass_sh;
    assign tnum_fwd    = tnum_wr ? wr_data_q : tnum_sh;
    assign run_start   = (state_q == ST_IDLE) && en_q;
    assign counting    = (state_q == ST_RUN) || (state_q == ST_SETTLE);
    assign timeout_hit = (64'(cycle_cnt) == 64'(TIMEOUT_CYC - 1));
    assign settle_last = (settle_cnt == SET_W'(SETTLE_CYC - 1));
    assign enter_fail  = ((state_q == ST_RUN) && (state_nx == ST_TIMEOUT)) ||
                         ((state_q == ST_SETTLE) && (state_nx == ST_FAIL));

    assign state       = state_q;
    assign cur_testnum = tnum_sh;

    // Register every input so no input reaches an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            jump_q    <= 1'b0;
        end else begin
            en_q      <= en;
            wr_en_q   <= wr_en;
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
            jump_q    <= jump_flag;
        end
    end

    // Next-state selection; a low enable always returns to IDLE.
    always_comb begin
        state_nx = state_q;
        if (!en_q) begin
            state_nx = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_nx = ST_RUN;
                ST_RUN: begin
                    if (done_wr)          state_nx = ST_SETTLE;
                    else if (timeout_hit) state_nx = ST_TIMEOUT;
                end
                ST_SETTLE: begin
                    if (settle_last) state_nx = pass_fwd ? ST_PASS : ST_FAIL;
                end
                ST_PASS:    state_nx = ST_PASS;
                ST_FAIL:    state_nx = ST_FAIL;
                ST_TIMEOUT: state_nx = ST_TIMEOUT;
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    // State register with registered verdict flags decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            state_q <= state_nx;
            done    <= (state_nx == ST_PASS) || (state_nx == ST_FAIL) || (state_nx == ST_TIMEOUT);
            pass    <= (state_nx == ST_PASS);
        end
    end

    // Settle delay counter, zero outside SETTLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (state_q == ST_SETTLE) begin
            settle_cnt <= settle_cnt + SET_W'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    // Saturating cycle and jump counters; cleared on run start, frozen otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            jump_cnt  <= '0;
        end else if (run_start) begin
            cycle_cnt <= '0;
            jump_cnt  <= '0;
        end else if (counting) begin
            if (cycle_cnt != '1)           cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (jump_q && jump_cnt != '1)  jump_cnt  <= jump_cnt + CNT_W'(1);
        end
    end

    // Shadow registers, test-number change strobe and failing test number.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_sh      <= 1'b0;
            tnum_sh      <= '0;
            testnum_chg  <= 1'b0;
            fail_testnum <= '0;
        end else begin
            testnum_chg <= (state_q != ST_IDLE) && tnum_wr && (wr_data_q != tnum_sh);
            if (run_start) begin
                pass_sh <= 1'b0;
                tnum_sh <= '0;
            end else if (state_q != ST_IDLE) begin
                if (pass_wr) pass_sh <= (wr_data_q == DATA_W'(1));
                if (tnum_wr) tnum_sh <= wr_data_q;
            end
            if (enter_fail) fail_testnum <= tnum_fwd;
        end
    end

endmodule
